// File: rtl/trace_pkg.sv
// Shared types for the writeback commit-trace buffer.
`default_nettype none

package trace_pkg;

  localparam int TRACE_XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    POST = 2'd2,
    DONE = 2'd3
  } trace_state_e;

  typedef enum logic [1:0] {
    TRIG_IMM   = 2'd0,
    TRIG_PC    = 2'd1,
    TRIG_INTR  = 2'd2,
    TRIG_FLUSH = 2'd3
  } trig_mode_e;

  typedef struct packed {
    logic [TRACE_XLEN-1:0] pc;
    logic [31:0]           instr;
    logic [4:0]            rd;
    logic                  reg_wr;
    logic [TRACE_XLEN-1:0] wb_data;
    logic                  intr;
    logic                  flush;
  } trace_entry_t;

endpackage

`default_nettype wire

// File: rtl/trace_ram.sv
// Trace storage: synchronous write port, asynchronous read port, no reset.
`default_nettype none

module trace_ram
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  trace_entry_t  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output trace_entry_t  rdata_o
);

  trace_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/wb_trace_buffer.sv
// Commit-trace capture beside WB: circular pre-trigger history, post-trigger
// window, then a valid/ready drain of the frozen buffer oldest-first.
`default_nettype none

module wb_trace_buffer
  import trace_pkg::*;
#(
  parameter int XLEN  = TRACE_XLEN,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            arm,
  input  logic [1:0]      trig_mode,
  input  logic [XLEN-1:0] trig_pc,
  input  logic [CW-1:0]   post_count,
  input  logic            ev_valid,
  input  logic [XLEN-1:0] ev_pc,
  input  logic [31:0]     ev_instr,
  input  logic [4:0]      ev_rd,
  input  logic            ev_reg_wr,
  input  logic [XLEN-1:0] ev_wb_data,
  input  logic            ev_intr,
  input  logic            ev_flush,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [XLEN-1:0] rd_pc,
  output logic [31:0]     rd_instr,
  output logic [4:0]      rd_rd,
  output logic            rd_reg_wr,
  output logic [XLEN-1:0] rd_wb_data,
  output logic            rd_intr,
  output logic            rd_flush,
  output logic [1:0]      state,
  output logic [CW-1:0]   fill_count,
  output logic            triggered
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [CW-1:0] MAX_POST = CW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [CW-1:0] ONE      = CW'(1);

  trace_state_e  state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] fill_q, fill_d;
  logic [CW-1:0] remaining_q, remaining_d;
  logic [CW-1:0] post_q, post_d;
  logic          trig_q, trig_d;

  logic          capture;
  logic          trig_hit;
  logic          pop;
  logic [AW-1:0] rd_ptr;
  trace_entry_t  wr_entry;
  trace_entry_t  rd_entry;
  trace_entry_t  rd_view;

  assign capture  = ev_valid && !arm && (state_q == PRE || state_q == POST);
  assign rd_valid = (state_q == DONE) && (fill_q != '0);
  assign pop      = rd_valid && rd_ready;
  // Oldest entry sits fill_count slots behind the write pointer; a full
  // buffer wraps to exactly wr_ptr.
  assign rd_ptr   = wr_ptr_q - fill_q[AW-1:0];

  assign wr_entry = '{pc: ev_pc, instr: ev_instr, rd: ev_rd, reg_wr: ev_reg_wr,
                      wb_data: ev_wb_data, intr: ev_intr, flush: ev_flush};

  always_comb begin
    trig_hit = 1'b0;
    case (trig_mode_e'(trig_mode))
      TRIG_IMM:   trig_hit = 1'b1;
      TRIG_PC:    trig_hit = (ev_pc == trig_pc);
      TRIG_INTR:  trig_hit = ev_intr;
      TRIG_FLUSH: trig_hit = ev_flush;
      default:    trig_hit = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    remaining_d = remaining_q;
    post_d      = post_q;
    trig_d      = trig_q;
    if (arm) begin
      state_d     = PRE;
      wr_ptr_d    = '0;
      fill_d      = '0;
      remaining_d = '0;
      trig_d      = 1'b0;
      post_d      = (post_count > MAX_POST) ? MAX_POST : post_count;
    end else begin
      if (capture) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (fill_q != FULL) fill_d = fill_q + ONE;
      end
      case (state_q)
        PRE: begin
          if (ev_valid && trig_hit) begin
            trig_d      = 1'b1;
            remaining_d = post_q;
            state_d     = (post_q == '0) ? DONE : POST;
          end
        end
        POST: begin
          if (ev_valid) begin
            remaining_d = remaining_q - ONE;
            if (remaining_q == ONE) state_d = DONE;
          end
        end
        DONE: begin
          if (pop) begin
            fill_d = fill_q - ONE;
            if (fill_q == ONE) state_d = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      remaining_q <= '0;
      post_q      <= '0;
      trig_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      remaining_q <= remaining_d;
      post_q      <= post_d;
      trig_q      <= trig_d;
    end
  end

  trace_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .we_i    (capture),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr),
    .rdata_o (rd_entry)
  );

  // RAM is never reset, so data is masked outside readout.
  assign rd_view    = (state_q == DONE) ? rd_entry : '0;
  assign rd_pc      = rd_view.pc;
  assign rd_instr   = rd_view.instr;
  assign rd_rd      = rd_view.rd;
  assign rd_reg_wr  = rd_view.reg_wr;
  assign rd_wb_data = rd_view.wb_data;
  assign rd_intr    = rd_view.intr;
  assign rd_flush   = rd_view.flush;

  assign state      = state_q;
  assign fill_count = fill_q;
  assign triggered  = trig_q;

endmodule

`default_nettype wire
